// File: rtl/perf_monitor_pkg.sv
// Shared definitions for the retirement/cache performance monitor:
// counter index map, read-select width and small decode helpers.
package perf_monitor_pkg;

    localparam int unsigned NUM_CNT = 8;
    localparam int unsigned SEL_W   = 3;

    localparam int unsigned CNT_CYCLES = 0;
    localparam int unsigned CNT_INST   = 1;
    localparam int unsigned CNT_LOADS  = 2;
    localparam int unsigned CNT_STALLS = 3;
    localparam int unsigned CNT_IC_REQ = 4;
    localparam int unsigned CNT_IC_HIT = 5;
    localparam int unsigned CNT_DC_REQ = 6;
    localparam int unsigned CNT_DC_HIT = 7;

    // A hit reported without its request is a protocol violation.
    function automatic logic unqual_hit(input logic req, input logic hit);
        return hit & ~req;
    endfunction

endpackage

// File: rtl/perf_sat_counter.sv
// Saturating event counter: synchronous reset/clear, +1 per enabled cycle,
// holds at all-ones instead of wrapping.
module perf_sat_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/perf_monitor.sv
// Writeback-side performance monitor: decodes commit/cache events into eight
// saturating counters, freezes on HALT, and serves a registered read port.
module perf_monitor
    import perf_monitor_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wb_reg_write_i,
    input  logic             wb_mem_write_i,
    input  logic             mem_read_i,
    input  logic             halt_i,
    input  logic             stall_i,
    input  logic             icache_req_i,
    input  logic             icache_hit_i,
    input  logic             dcache_req_i,
    input  logic             dcache_hit_i,
    input  logic             clr_i,
    input  logic             rd_en_i,
    input  logic [SEL_W-1:0] rd_sel_i,
    output logic             rd_valid_o,
    output logic [CNT_W-1:0] rd_data_o,
    output logic             halted_o,
    output logic             proto_err_o
);

    logic [NUM_CNT-1:0] evt_c;
    logic [NUM_CNT-1:0] inc_c;
    logic [CNT_W-1:0]   cnt_c [NUM_CNT];

    logic             halted_q,    halted_d;
    logic             proto_err_q, proto_err_d;
    logic             rd_valid_q,  rd_valid_d;
    logic [CNT_W-1:0] rd_data_q,   rd_data_d;

    // Event decode; hits only count when qualified by their request.
    always_comb begin
        evt_c             = '0;
        evt_c[CNT_CYCLES] = 1'b1;
        evt_c[CNT_INST]   = halt_i | wb_reg_write_i | wb_mem_write_i;
        evt_c[CNT_LOADS]  = mem_read_i;
        evt_c[CNT_STALLS] = stall_i;
        evt_c[CNT_IC_REQ] = icache_req_i;
        evt_c[CNT_IC_HIT] = icache_hit_i & icache_req_i;
        evt_c[CNT_DC_REQ] = dcache_req_i;
        evt_c[CNT_DC_HIT] = dcache_hit_i & dcache_req_i;
        inc_c             = (halted_q || clr_i) ? '0 : evt_c;
    end

    for (genvar g = 0; g < NUM_CNT; g++) begin : g_cnt
        perf_sat_counter #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .clr_i (clr_i),
            .inc_i (inc_c[g]),
            .cnt_o (cnt_c[g])
        );
    end

    // Read samples counters before this edge's update or clear.
    always_comb begin
        halted_d    = halted_q;
        proto_err_d = proto_err_q;
        rd_valid_d  = rd_en_i;
        rd_data_d   = rd_data_q;
        if (clr_i) begin
            halted_d = 1'b0;
        end else if (halt_i) begin
            halted_d = 1'b1;
        end
        if (unqual_hit(icache_req_i, icache_hit_i) ||
            unqual_hit(dcache_req_i, dcache_hit_i)) begin
            proto_err_d = 1'b1;
        end
        if (rd_en_i) begin
            rd_data_d = cnt_c[rd_sel_i];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            halted_q    <= 1'b0;
            proto_err_q <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            halted_q    <= halted_d;
            proto_err_q <= proto_err_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
        end
    end

    assign rd_valid_o  = rd_valid_q;
    assign rd_data_o   = rd_data_q;
    assign halted_o    = halted_q;
    assign proto_err_o = proto_err_q;

endmodule

// File: tb/tb_perf_monitor.sv
// Directed self-checking bench for perf_monitor; a second CNT_W=4 instance
// shares the stimulus to exercise saturation.
`timescale 1ns/1ps
module tb_perf_monitor;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_reg_write, wb_mem_write, mem_read, halt, stall;
    logic        icache_req, icache_hit, dcache_req, dcache_hit;
    logic        clr, rd_en;
    logic [2:0]  rd_sel;
    logic        rd_valid, halted, proto_err;
    logic [31:0] rd_data;
    logic        rd_valid_w4, halted_w4, proto_err_w4;
    logic [3:0]  rd_data_w4;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    perf_monitor #(.CNT_W(32)) u_dut (
        .clk_i(clk), .rst_i(rst),
        .wb_reg_write_i(wb_reg_write), .wb_mem_write_i(wb_mem_write),
        .mem_read_i(mem_read), .halt_i(halt), .stall_i(stall),
        .icache_req_i(icache_req), .icache_hit_i(icache_hit),
        .dcache_req_i(dcache_req), .dcache_hit_i(dcache_hit),
        .clr_i(clr), .rd_en_i(rd_en), .rd_sel_i(rd_sel),
        .rd_valid_o(rd_valid), .rd_data_o(rd_data),
        .halted_o(halted), .proto_err_o(proto_err)
    );

    perf_monitor #(.CNT_W(4)) u_dut_w4 (
        .clk_i(clk), .rst_i(rst),
        .wb_reg_write_i(wb_reg_write), .wb_mem_write_i(wb_mem_write),
        .mem_read_i(mem_read), .halt_i(halt), .stall_i(stall),
        .icache_req_i(icache_req), .icache_hit_i(icache_hit),
        .dcache_req_i(dcache_req), .dcache_hit_i(dcache_hit),
        .clr_i(clr), .rd_en_i(rd_en), .rd_sel_i(rd_sel),
        .rd_valid_o(rd_valid_w4), .rd_data_o(rd_data_w4),
        .halted_o(halted_w4), .proto_err_o(proto_err_w4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wb_reg_write = 0; wb_mem_write = 0; mem_read = 0; halt = 0; stall = 0;
        icache_req = 0; icache_hit = 0; dcache_req = 0; dcache_hit = 0;
        clr = 0; rd_en = 0; rd_sel = 3'd0;
    endtask

    task automatic do_read(input logic [2:0] sel);
        rd_en = 1; rd_sel = sel;
        tick();
        rd_en = 0;
    endtask

    task automatic do_clr();
        clr = 1;
        tick();
        clr = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        tick(); tick();
        n_vec++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL reset_rd_valid: got %b want 0", rd_valid); end
        n_vec++; if (rd_data !== 32'd0) begin n_err++; $display("FAIL reset_rd_data: got %0d want 0", rd_data); end
        n_vec++; if (halted !== 1'b0) begin n_err++; $display("FAIL reset_halted: got %b want 0", halted); end
        n_vec++; if (proto_err !== 1'b0) begin n_err++; $display("FAIL reset_proto_err: got %b want 0", proto_err); end
        n_vec++; if ({halted_w4, proto_err_w4} !== 2'b00) begin n_err++; $display("FAIL reset_w4_flags: got %b want 00", {halted_w4, proto_err_w4}); end
        rst = 0;
        repeat (10) tick();
        do_read(3'd0);
        n_vec++; if (rd_valid !== 1'b1) begin n_err++; $display("FAIL idle_rd_valid: got %b want 1", rd_valid); end
        n_vec++; if (rd_data !== 32'd10) begin n_err++; $display("FAIL idle_cycles: got %0d want 10", rd_data); end
        tick();
        n_vec++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL rd_valid_drop: got %b want 0", rd_valid); end
        n_vec++; if (rd_data !== 32'd10) begin n_err++; $display("FAIL rd_data_hold: got %0d want 10", rd_data); end
        for (int i = 1; i < 8; i++) begin
            rd_en = 1; rd_sel = 3'(i);
            tick();
            n_vec++; if (rd_valid !== 1'b1 || rd_data !== 32'd0) begin
                n_err++; $display("FAIL idle_idx%0d: got valid=%b data=%0d want valid=1 data=0", i, rd_valid, rd_data);
            end
        end
        rd_en = 0;
    endtask

    task automatic test_back_to_back();
        do_clr();
        for (int k = 0; k < 3; k++) begin
            rd_en = 1; rd_sel = 3'd0;
            tick();
            n_vec++; if (rd_valid !== 1'b1 || rd_data !== 32'(k)) begin
                n_err++; $display("FAIL b2b_read%0d: got valid=%b data=%0d want valid=1 data=%0d", k, rd_valid, rd_data, k);
            end
        end
        rd_en = 0;
    endtask

    task automatic test_inst_halt();
        int exp_cnt [8];
        exp_cnt = '{9, 9, 0, 0, 0, 0, 0, 0};
        do_clr();
        wb_reg_write = 1; repeat (5) tick(); wb_reg_write = 0;
        wb_mem_write = 1; repeat (3) tick(); wb_mem_write = 0;
        n_vec++; if (halted !== 1'b0) begin n_err++; $display("FAIL pre_halt: got %b want 0", halted); end
        halt = 1; tick(); halt = 0;
        n_vec++; if (halted !== 1'b1) begin n_err++; $display("FAIL halt_set: got %b want 1", halted); end
        for (int i = 0; i < 20; i++) begin
            wb_reg_write = 1; mem_read = 1; stall = 1; icache_req = 1; dcache_req = 1;
            halt = (i == 5);
            tick();
        end
        idle_inputs();
        n_vec++; if (halted !== 1'b1) begin n_err++; $display("FAIL halt_sticky: got %b want 1", halted); end
        for (int i = 0; i < 8; i++) begin
            do_read(3'(i));
            n_vec++; if (rd_data !== 32'(exp_cnt[i])) begin
                n_err++; $display("FAIL frozen_idx%0d: got %0d want %0d", i, rd_data, exp_cnt[i]);
            end
        end
    endtask

    task automatic test_cache();
        logic [5:0] ic_hit_pat;
        int exp_cnt [8];
        ic_hit_pat = 6'b101011;
        exp_cnt = '{7, 0, 2, 0, 6, 4, 3, 2};
        do_clr();
        n_vec++; if (halted !== 1'b0) begin n_err++; $display("FAIL clr_halted: got %b want 0", halted); end
        n_vec++; if (proto_err !== 1'b0) begin n_err++; $display("FAIL cache_pre_proto: got %b want 0", proto_err); end
        for (int i = 0; i < 6; i++) begin
            icache_req = 1; icache_hit = ic_hit_pat[i];
            mem_read = (i < 2);
            dcache_req = (i < 3); dcache_hit = (i == 0 || i == 2);
            tick();
        end
        idle_inputs();
        icache_hit = 1; tick(); icache_hit = 0;
        n_vec++; if (proto_err !== 1'b1) begin n_err++; $display("FAIL proto_err_set: got %b want 1", proto_err); end
        for (int i = 0; i < 8; i++) begin
            rd_en = 1; rd_sel = 3'(i);
            tick();
            n_vec++; if (rd_valid !== 1'b1 || rd_data !== 32'(exp_cnt[i])) begin
                n_err++; $display("FAIL cache_idx%0d: got valid=%b data=%0d want valid=1 data=%0d", i, rd_valid, rd_data, exp_cnt[i]);
            end
        end
        rd_en = 0;
        do_clr();
        n_vec++; if (proto_err !== 1'b1) begin n_err++; $display("FAIL proto_err_through_clr: got %b want 1", proto_err); end
        do_read(3'd4);
        n_vec++; if (rd_data !== 32'd0) begin n_err++; $display("FAIL clr_idx4: got %0d want 0", rd_data); end
    endtask

    task automatic test_saturation();
        do_clr();
        stall = 1; repeat (20) tick(); stall = 0;
        do_read(3'd3);
        n_vec++; if (rd_valid_w4 !== 1'b1 || rd_data_w4 !== 4'd15) begin
            n_err++; $display("FAIL sat_w4_stall: got valid=%b data=%0d want valid=1 data=15", rd_valid_w4, rd_data_w4);
        end
        n_vec++; if (rd_data !== 32'd20) begin n_err++; $display("FAIL sat_w32_stall: got %0d want 20", rd_data); end
        do_read(3'd0);
        n_vec++; if (rd_data_w4 !== 4'd15) begin n_err++; $display("FAIL sat_w4_cycles: got %0d want 15", rd_data_w4); end
        n_vec++; if (rd_data !== 32'd21) begin n_err++; $display("FAIL sat_w32_cycles: got %0d want 21", rd_data); end
    endtask

    task automatic test_clr_race();
        do_clr();
        dcache_req = 1; repeat (7) tick(); dcache_req = 0;
        halt = 1; tick(); halt = 0;
        n_vec++; if (halted !== 1'b1) begin n_err++; $display("FAIL race_pre_halted: got %b want 1", halted); end
        clr = 1; dcache_req = 1; rd_en = 1; rd_sel = 3'd6;
        tick();
        idle_inputs();
        n_vec++; if (rd_valid !== 1'b1 || rd_data !== 32'd7) begin
            n_err++; $display("FAIL race_read: got valid=%b data=%0d want valid=1 data=7", rd_valid, rd_data);
        end
        n_vec++; if (halted !== 1'b0) begin n_err++; $display("FAIL race_halted_clr: got %b want 0", halted); end
        do_read(3'd6);
        n_vec++; if (rd_data !== 32'd0) begin n_err++; $display("FAIL race_event_lost: got %0d want 0", rd_data); end
        do_read(3'd0);
        n_vec++; if (rd_data !== 32'd1) begin n_err++; $display("FAIL race_cycles_resume: got %0d want 1", rd_data); end
    endtask

    task automatic test_rst_mid_read();
        do_clr();
        wb_reg_write = 1; repeat (3) tick(); wb_reg_write = 0;
        rd_en = 1; rd_sel = 3'd1;
        tick();
        n_vec++; if (rd_valid !== 1'b1 || rd_data !== 32'd3) begin
            n_err++; $display("FAIL mid_read: got valid=%b data=%0d want valid=1 data=3", rd_valid, rd_data);
        end
        rst = 1; rd_sel = 3'd0;
        tick();
        rd_en = 0; rst = 0;
        n_vec++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL rst_read_discard: got %b want 0", rd_valid); end
        n_vec++; if (rd_data !== 32'd0) begin n_err++; $display("FAIL rst_rd_data: got %0d want 0", rd_data); end
        n_vec++; if (proto_err !== 1'b0) begin n_err++; $display("FAIL rst_proto_err: got %b want 0", proto_err); end
        for (int i = 0; i < 8; i++) begin
            rd_en = 1; rd_sel = 3'(i);
            tick();
            n_vec++; if (rd_valid !== 1'b1 || rd_data !== 32'd0) begin
                n_err++; $display("FAIL post_rst_idx%0d: got valid=%b data=%0d want valid=1 data=0", i, rd_valid, rd_data);
            end
        end
        rd_en = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_back_to_back();
        test_inst_halt();
        test_cache();
        test_saturation();
        test_clr_race();
        test_rst_mid_read();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
